// File: rtl/change_logger_pkg.sv
// Shared types for the change logger: FSM state encoding and the default event record layout.
package change_logger_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned TS_WIDTH = 16;

  typedef enum logic {
    BASELINE,
    ARMED
  } state_t;

  // Record layout at the default widths; the top rebuilds it at its own parameter widths.
  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    prev;
    logic [WIDTH-1:0]    value;
  } event_t;

endpackage

// File: rtl/change_logger_event_fifo.sv
// Single-clock FIFO for change records; a pop frees room for a push in the same cycle.
module change_logger_event_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic                      pop_i,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH[AW:0]);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/change_logger.sv
// Samples in_data every clock and queues a timestamped {prev, value} record whenever it
// changes (4-state compare); records drain through a valid/ready port.
module change_logger #(
  parameter int unsigned WIDTH    = change_logger_pkg::WIDTH,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TS_WIDTH = change_logger_pkg::TS_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_value,
  output logic [WIDTH-1:0]       out_prev,
  output logic [TS_WIDTH-1:0]    out_ts,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  import change_logger_pkg::*;

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    prev;
    logic [WIDTH-1:0]    value;
  } rec_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                overflow_q, overflow_d;
  logic                push, pop, full, empty;
  rec_t                push_rec, head_rec;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_value = head_rec.value;
  assign out_prev  = head_rec.prev;
  assign out_ts    = head_rec.ts;
  assign overflow  = overflow_q;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      BASELINE: state_d = ARMED;
      ARMED:    push = (in_data !== prev_q);
      default:  state_d = BASELINE;
    endcase
    // The sample register tracks every edge, even when the record itself is dropped.
    prev_d         = in_data;
    ts_d           = ts_q + 1'b1;
    overflow_d     = overflow_q | (push && full && !pop);
    push_rec.ts    = ts_q;
    push_rec.prev  = prev_q;
    push_rec.value = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BASELINE;
      prev_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
    end
  end

  change_logger_event_fifo #(
    .DATA_WIDTH ($bits(rec_t)),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (push_rec),
    .pop_i   (pop),
    .data_o  (head_rec),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

endmodule

// File: tb/tb_change_logger.sv
// Bench for change_logger: a scoreboard predicts records from the driven stimulus and checks
// every record as it drains; scenario tasks add targeted checks.
module tb_change_logger;

  localparam int unsigned D = 4;

  typedef struct packed {
    logic [15:0] ts;
    logic [7:0]  prev;
    logic [7:0]  value;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;

  logic        out_valid, overflow;
  logic [7:0]  out_value, out_prev;
  logic [15:0] out_ts;
  logic [2:0]  level;

  logic        v4_valid, v4_ovf;
  logic [7:0]  v4_value, v4_prev;
  logic [3:0]  v4_ts;
  logic [2:0]  v4_level;

  int   total = 0;
  int   bad = 0;
  int   n_popped = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  change_logger dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_prev  (out_prev),
    .out_ts    (out_ts),
    .overflow  (overflow),
    .level     (level)
  );

  change_logger #(.TS_WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .out_valid (v4_valid),
    .out_ready (out_ready),
    .out_value (v4_value),
    .out_prev  (v4_prev),
    .out_ts    (v4_ts),
    .overflow  (v4_ovf),
    .level     (v4_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [7:0] v, input logic rdy);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_data = v;
    out_ready = rdy;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Model updates on rising edges, checks the DUT on falling edges.
  task automatic scoreboard();
    rec_t       e;
    int         cyc;
    int         m_cnt;
    logic       m_armed;
    logic       m_ovf;
    logic [7:0] m_prev;
    cyc = 0; m_cnt = 0; m_armed = 1'b0; m_ovf = 1'b0; m_prev = '0;
    forever begin
      @(posedge clk or negedge clk or posedge rst);
      if (rst) begin
        cyc = 0; m_cnt = 0; m_armed = 1'b0; m_ovf = 1'b0; m_prev = '0;
        exp_q.delete();
      end else if (clk) begin
        if (m_cnt > 0 && out_ready) m_cnt--;
        if (m_armed && (in_data !== m_prev)) begin
          if (m_cnt < D) begin
            e.ts = cyc[15:0];
            e.prev = m_prev;
            e.value = in_data;
            exp_q.push_back(e);
            m_cnt++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        m_prev = in_data;
        m_armed = 1'b1;
        cyc++;
      end else begin
        total++;
        if (out_valid !== (m_cnt > 0)) begin
          bad++;
          $display("FAIL sb_valid: got %b want %b", out_valid, (m_cnt > 0));
        end
        total++;
        if (level !== 3'(m_cnt)) begin
          bad++;
          $display("FAIL sb_level: got %0d want %0d", level, m_cnt);
        end
        total++;
        if (overflow !== m_ovf) begin
          bad++;
          $display("FAIL sb_overflow: got %b want %b", overflow, m_ovf);
        end
        if (m_cnt > 0 && exp_q.size() > 0) begin
          e = exp_q[0];
          total++;
          if ({out_ts, out_prev, out_value} !== e) begin
            bad++;
            $display("FAIL sb_record: got ts=%h prev=%h value=%h want ts=%h prev=%h value=%h",
                     out_ts, out_prev, out_value, e.ts, e.prev, e.value);
          end
          if (out_ready) e = exp_q.pop_front();
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) n_popped++;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_data = 8'h00;
    out_ready = 1'b1;
    #2;
    total++;
    if ({out_valid, overflow, level, out_value, out_prev, out_ts} !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b o=%b l=%0d val=%h prev=%h ts=%h want all zero",
               out_valid, overflow, level, out_value, out_prev, out_ts);
    end
    total++;
    if ({v4_valid, v4_ovf, v4_level, v4_value, v4_prev, v4_ts} !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs_ts4: got v=%b o=%b l=%0d ts=%h want all zero",
               v4_valid, v4_ovf, v4_level, v4_ts);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (10) begin
      tick();
      @(negedge clk);
      total++;
      if ({out_valid, overflow, level} !== 5'd0) begin
        bad++;
        $display("FAIL idle_quiet: got v=%b o=%b l=%0d want 0 0 0", out_valid, overflow, level);
      end
    end
  endtask

  task automatic test_single_change();
    int p0;
    apply_reset(8'h00, 1'b1);
    p0 = n_popped;
    tick();
    tick();
    tick();
    in_data = 8'h5A;
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_ts !== 16'd3 || out_prev !== 8'h00 || out_value !== 8'h5A) begin
      bad++;
      $display("FAIL single_rec: got v=%b ts=%0d prev=%h val=%h want 1 3 00 5a",
               out_valid, out_ts, out_prev, out_value);
    end
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_valid_drop: got %b want 0", out_valid);
    end
    repeat (3) tick();
    total++;
    if (n_popped - p0 !== 1) begin
      bad++;
      $display("FAIL single_count: got %0d want 1", n_popped - p0);
    end
  endtask

  task automatic test_overflow();
    apply_reset(8'h00, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i);
      tick();
    end
    @(negedge clk);
    total++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_full: got level=%0d ovf=%b want 4 1", level, overflow);
    end
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_value !== 8'(i) || out_prev !== 8'(i - 1)) begin
        bad++;
        $display("FAIL ovf_drain: got v=%b val=%h prev=%h want 1 %h %h",
                 out_valid, out_value, out_prev, 8'(i), 8'(i - 1));
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      bad++;
      $display("FAIL ovf_empty: got v=%b level=%0d want 0 0", out_valid, level);
    end
    tick();
    in_data = 8'h06;
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_prev !== 8'h05 || out_value !== 8'h06 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_true_prev: got v=%b prev=%h val=%h ovf=%b want 1 05 06 1",
               out_valid, out_prev, out_value, overflow);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    apply_reset(8'h00, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      tick();
    end
    @(negedge clk);
    total++;
    if (level !== 3'd4 || out_value !== 8'h01) begin
      bad++;
      $display("FAIL fpp_fill: got level=%0d head=%h want 4 01", level, out_value);
    end
    tick();
    in_data = 8'h05;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (level !== 3'd4 || overflow !== 1'b0 || out_value !== 8'h02) begin
      bad++;
      $display("FAIL fpp_both: got level=%0d ovf=%b head=%h want 4 0 02", level, overflow, out_value);
    end
    tick();
    out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    total++;
    if (level !== 3'd0) begin
      bad++;
      $display("FAIL fpp_drain: got level=%0d want 0", level);
    end
  endtask

  task automatic test_xz();
    logic [7:0] seq [4];
    int         p0;
    int         exp_n;
    seq[0] = 8'h00;
    seq[1] = 8'hxx;
    seq[2] = 8'hxx;
    seq[3] = 8'h00;
    apply_reset(seq[0], 1'b1);
    tick();
    p0 = n_popped;
    exp_n = 0;
    for (int i = 1; i < 4; i++) begin
      in_data = seq[i];
      if (seq[i] !== seq[i - 1]) exp_n++;
      tick();
    end
    repeat (3) tick();
    total++;
    if (n_popped - p0 !== exp_n) begin
      bad++;
      $display("FAIL xz_count: got %0d want %0d", n_popped - p0, exp_n);
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset(8'h00, 1'b1);
    repeat (17) tick();
    in_data = 8'hAA;
    tick();
    @(negedge clk);
    total++;
    if (v4_valid !== 1'b1 || v4_ts !== 4'd1 || v4_value !== 8'hAA) begin
      bad++;
      $display("FAIL wrap_ts: got v=%b ts=%0d val=%h want 1 1 aa", v4_valid, v4_ts, v4_value);
    end
    tick();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'(i);
      tick();
    end
    @(negedge clk);
    total++;
    if (level !== 3'd3 || v4_level !== 3'd3) begin
      bad++;
      $display("FAIL rst_queued: got level=%0d ts4_level=%0d want 3 3", level, v4_level);
    end
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, level, overflow, v4_valid, v4_level, v4_ovf} !== 10'd0) begin
      bad++;
      $display("FAIL rst_async: got v=%b l=%0d o=%b v4=%b l4=%0d o4=%b want all zero",
               out_valid, level, overflow, v4_valid, v4_level, v4_ovf);
    end
    in_data = 8'h77;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_rebaseline: got v=%b want 0", out_valid);
    end
    tick();
    tick();
    in_data = 8'h78;
    tick();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_ts !== 16'd3 || out_prev !== 8'h77 || out_value !== 8'h78) begin
      bad++;
      $display("FAIL rst_first_rec: got v=%b ts=%0d prev=%h val=%h want 1 3 77 78",
               out_valid, out_ts, out_prev, out_value);
    end
    tick();
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_single_change();
    test_overflow();
    test_full_push_pop();
    test_xz();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
